// File: rtl/gpio_pkg.sv
// Shared definitions for the gpio block: the register address map and the default data width.
package gpio_pkg;

    localparam int GPIO_WIDTH = 32;

    localparam logic [1:0] GPIO_ADDR_GPI1 = 2'b00;
    localparam logic [1:0] GPIO_ADDR_GPI2 = 2'b01;
    localparam logic [1:0] GPIO_ADDR_GPO1 = 2'b10;
    localparam logic [1:0] GPIO_ADDR_GPO2 = 2'b11;

endpackage : gpio_pkg

// File: rtl/gpio_reg.sv
// WIDTH-bit register with load enable and asynchronous active-high clear.
// Holds the output registers, and also forms the input synchronizer stages.
module gpio_reg
    import gpio_pkg::*;
#(
    parameter int WIDTH = GPIO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : gpio_reg

// File: rtl/gpio.sv
// Memory-mapped GPIO: two input ports and two output registers behind a 2-bit word address.
// Define GPIO_INPUT_SYNC_EN to pass gpi1/gpi2 through 2-flop synchronizers before the read mux.
module gpio
    import gpio_pkg::*;
#(
    parameter int WIDTH = GPIO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wd,
    input  logic [WIDTH-1:0] gpi1,
    input  logic [WIDTH-1:0] gpi2,
    output logic [WIDTH-1:0] gpo1,
    output logic [WIDTH-1:0] gpo2,
    output logic [WIDTH-1:0] rd
);

    logic             wr_gpo1;
    logic             wr_gpo2;
    logic [WIDTH-1:0] gpi1_s;
    logic [WIDTH-1:0] gpi2_s;

    assign wr_gpo1 = we && (addr == GPIO_ADDR_GPO1);
    assign wr_gpo2 = we && (addr == GPIO_ADDR_GPO2);

    gpio_reg #(.WIDTH(WIDTH)) u_gpo1 (
        .clk (clk),
        .rst (rst),
        .en  (wr_gpo1),
        .d   (wd),
        .q   (gpo1)
    );

    gpio_reg #(.WIDTH(WIDTH)) u_gpo2 (
        .clk (clk),
        .rst (rst),
        .en  (wr_gpo2),
        .d   (wd),
        .q   (gpo2)
    );

`ifdef GPIO_INPUT_SYNC_EN
    logic [WIDTH-1:0] gpi1_meta;
    logic [WIDTH-1:0] gpi2_meta;

    // Two always-enabled stages per input; rd sees an input change two edges later.
    gpio_reg #(.WIDTH(WIDTH)) u_gpi1_s1 (.clk(clk), .rst(rst), .en(1'b1), .d(gpi1),      .q(gpi1_meta));
    gpio_reg #(.WIDTH(WIDTH)) u_gpi1_s2 (.clk(clk), .rst(rst), .en(1'b1), .d(gpi1_meta), .q(gpi1_s));
    gpio_reg #(.WIDTH(WIDTH)) u_gpi2_s1 (.clk(clk), .rst(rst), .en(1'b1), .d(gpi2),      .q(gpi2_meta));
    gpio_reg #(.WIDTH(WIDTH)) u_gpi2_s2 (.clk(clk), .rst(rst), .en(1'b1), .d(gpi2_meta), .q(gpi2_s));
`else
    assign gpi1_s = gpi1;
    assign gpi2_s = gpi2;
`endif

    always_comb begin
        rd = '0;
        case (addr)
            GPIO_ADDR_GPI1: rd = gpi1_s;
            GPIO_ADDR_GPI2: rd = gpi2_s;
            GPIO_ADDR_GPO1: rd = gpo1;
            GPIO_ADDR_GPO2: rd = gpo2;
        endcase
    end

endmodule : gpio

// File: tb/tb_gpio.sv
// Directed testbench for gpio (default build, input synchronizers disabled).
module tb_gpio;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] gpi1;
    logic [31:0] gpi2;
    logic [31:0] gpo1;
    logic [31:0] gpo2;
    logic [31:0] rd;

    int checkCount;
    int errorCount;

    gpio #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .wd   (wd),
        .gpi1 (gpi1),
        .gpi2 (gpi2),
        .gpo1 (gpo1),
        .gpo2 (gpo2),
        .rd   (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d);
        we   = w;
        addr = a;
        wd   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst  = 1'b1;
        gpi1 = 32'h0;
        gpi2 = 32'h0;
        applyStimulus(1'b0, 2'b00, 32'h0);
        tick();

        // Reset state
        checkOutput("reset_gpo1", gpo1, 32'h0);
        checkOutput("reset_gpo2", gpo2, 32'h0);
        applyStimulus(1'b0, 2'b10, 32'h0);
        #1 checkOutput("reset_rd_gpo1", rd, 32'h0);
        applyStimulus(1'b0, 2'b11, 32'h0);
        #1 checkOutput("reset_rd_gpo2", rd, 32'h0);

        // Write blocked while reset is held; inputs still readable
        applyStimulus(1'b1, 2'b10, 32'h000000AA);
        tick();
        checkOutput("reset_blocks_write", gpo1, 32'h0);
        gpi1 = 32'h00000011;
        applyStimulus(1'b0, 2'b00, 32'h0);
        #1 checkOutput("reset_rd_gpi1", rd, 32'h00000011);

        rst = 1'b0;
        tick();

        // Write gpo1
        applyStimulus(1'b1, 2'b10, 32'd5);
        tick();
        checkOutput("wr_gpo1", gpo1, 32'd5);
        checkOutput("wr_gpo1_rd", rd, 32'd5);
        checkOutput("wr_gpo1_gpo2_hold", gpo2, 32'h0);

        // Write gpo2
        applyStimulus(1'b1, 2'b11, 32'd5);
        tick();
        checkOutput("wr_gpo2", gpo2, 32'd5);
        checkOutput("wr_gpo2_gpo1_hold", gpo1, 32'd5);
        checkOutput("wr_gpo2_rd", rd, 32'd5);

        // Read during write: old value before the edge, new after
        applyStimulus(1'b1, 2'b10, 32'h12345678);
        #1 checkOutput("rdw_before", rd, 32'd5);
        tick();
        checkOutput("rdw_after", rd, 32'h12345678);
        checkOutput("rdw_gpo2_hold", gpo2, 32'd5);

        // Reset between edges clears outputs immediately
        applyStimulus(1'b0, 2'b11, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_gpo1", gpo1, 32'h0);
        checkOutput("async_rst_gpo2", gpo2, 32'h0);
        checkOutput("async_rst_rd", rd, 32'h0);
        rst = 1'b0;
        tick();

        // Rewrite both, then reset coinciding with a write
        applyStimulus(1'b1, 2'b10, 32'd5);
        tick();
        applyStimulus(1'b1, 2'b11, 32'd5);
        tick();
        checkOutput("rewrite_gpo1", gpo1, 32'd5);
        checkOutput("rewrite_gpo2", gpo2, 32'd5);
        applyStimulus(1'b1, 2'b10, 32'h00000077);
        rst = 1'b1;
        tick();
        checkOutput("rst_wins_gpo1", gpo1, 32'h0);
        checkOutput("rst_wins_gpo2", gpo2, 32'h0);
        applyStimulus(1'b0, 2'b10, 32'h0);
        rst = 1'b0;
        tick();

        // Input reads
        gpi1 = 32'd5;
        gpi2 = 32'd5;
        applyStimulus(1'b0, 2'b00, 32'h0);
        #1 checkOutput("rd_gpi1", rd, 32'd5);
        applyStimulus(1'b0, 2'b01, 32'h0);
        #1 checkOutput("rd_gpi2", rd, 32'd5);
        gpi2 = 32'hA5A5_0F0F;
        #1 checkOutput("rd_gpi2_pattern", rd, 32'hA5A5_0F0F);
        gpi1 = 32'hDEADBEEF;
        applyStimulus(1'b0, 2'b00, 32'h0);
        #1 checkOutput("rd_gpi1_comb", rd, 32'hDEADBEEF);

        // Ignored writes
        applyStimulus(1'b1, 2'b10, 32'h0000_1234);
        tick();
        applyStimulus(1'b1, 2'b00, 32'hFFFFFFFF);
        tick();
        checkOutput("ign_wr00_gpo1", gpo1, 32'h0000_1234);
        checkOutput("ign_wr00_gpo2", gpo2, 32'h0);
        checkOutput("ign_wr00_rd", rd, 32'hDEADBEEF);
        applyStimulus(1'b1, 2'b01, 32'hFFFFFFFF);
        tick();
        checkOutput("ign_wr01_gpo1", gpo1, 32'h0000_1234);
        checkOutput("ign_wr01_gpo2", gpo2, 32'h0);
        applyStimulus(1'b0, 2'b10, 32'hCAFEF00D);
        tick();
        checkOutput("we0_gpo1_hold", gpo1, 32'h0000_1234);
        checkOutput("we0_rd_hold", rd, 32'h0000_1234);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule : tb_gpio
